// File: rtl/spi_cmd_sequencer.sv
// Command sequencer driving a register-mapped SPI master: selects the slave, shifts
// 1-4 bytes with status polling, deselects, and returns the received bytes.
module spi_cmd_sequencer #(
    parameter int POLL_LIMIT = 1023
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_len,
    input  logic [31:0] cmd_wdata,
    input  logic [15:0] cmd_ss,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [2:0]  mem_addr,
    output logic [15:0] data_from_cpu,
    input  logic [15:0] data_to_cpu,
    output logic        spi_select,
    output logic        read_n,
    output logic        write_n
);

    localparam int PW = $clog2(POLL_LIMIT + 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_LIMIT - 1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_WR_SS     = 4'd1,
        S_SSO_ON    = 4'd2,
        S_POLL_TRDY = 4'd3,
        S_WR_TX     = 4'd4,
        S_POLL_RRDY = 4'd5,
        S_RD_RX     = 4'd6,
        S_POLL_TMT  = 4'd7,
        S_SSO_OFF   = 4'd8,
        S_DONE      = 4'd9
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     ph_q, ph_d;
    logic [1:0]     idx_q, idx_d;
    logic [1:0]     len_q, len_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [15:0]    ss_q, ss_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           err_q, err_d;
    logic [PW-1:0]  poll_cnt_q, poll_cnt_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           cmd_ready_q, cmd_ready_d;
    logic           spi_select_q, spi_select_d;
    logic           read_n_q, read_n_d;
    logic           write_n_q, write_n_d;
    logic [2:0]     mem_addr_q, mem_addr_d;
    logic [15:0]    data_q, data_d;

    logic           bus_state_s;
    logic           bus_rd_s;
    logic [2:0]     bus_addr_s;
    logic [15:0]    bus_data_s;
    logic           poll_s;
    logic           poll_bit_s;
    state_t         poll_next_s;
    logic [7:0]     tx_byte_s;
    logic           active_s;
    logic           unused_s;

    assign unused_s = ^data_to_cpu[15:8];

    // Transmit byte selection, most significant byte first.
    always_comb begin
        case (idx_q)
            2'd0:    tx_byte_s = wdata_q[31:24];
            2'd1:    tx_byte_s = wdata_q[23:16];
            2'd2:    tx_byte_s = wdata_q[15:8];
            default: tx_byte_s = wdata_q[7:0];
        endcase
    end

    // Per-state bus access decode and poll target.
    always_comb begin
        bus_state_s = 1'b1;
        bus_rd_s    = 1'b0;
        bus_addr_s  = 3'd0;
        bus_data_s  = 16'h0000;
        poll_s      = 1'b0;
        poll_bit_s  = 1'b0;
        poll_next_s = S_IDLE;
        case (state_q)
            S_WR_SS:     begin bus_addr_s = 3'd5; bus_data_s = ss_q; end
            S_SSO_ON:    begin bus_addr_s = 3'd3; bus_data_s = 16'h0400; end
            S_POLL_TRDY: begin
                bus_rd_s = 1'b1; bus_addr_s = 3'd2; poll_s = 1'b1;
                poll_bit_s = data_to_cpu[6]; poll_next_s = S_WR_TX;
            end
            S_WR_TX:     begin bus_addr_s = 3'd1; bus_data_s = {8'h00, tx_byte_s}; end
            S_POLL_RRDY: begin
                bus_rd_s = 1'b1; bus_addr_s = 3'd2; poll_s = 1'b1;
                poll_bit_s = data_to_cpu[7]; poll_next_s = S_RD_RX;
            end
            S_RD_RX:     begin bus_rd_s = 1'b1; bus_addr_s = 3'd0; end
            S_POLL_TMT:  begin
                bus_rd_s = 1'b1; bus_addr_s = 3'd2; poll_s = 1'b1;
                poll_bit_s = data_to_cpu[5]; poll_next_s = S_SSO_OFF;
            end
            S_SSO_OFF:   begin bus_addr_s = 3'd3; bus_data_s = 16'h0000; end
            default:     bus_state_s = 1'b0;
        endcase
    end

    // Phase 0 of every bus state is the idle gap; phases 1-2 hold the access,
    // and the edge leaving phase 2 samples read data and picks the next state.
    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        idx_d       = idx_q;
        len_d       = len_q;
        wdata_d     = wdata_q;
        ss_d        = ss_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        poll_cnt_d  = poll_cnt_q;
        rsp_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    len_d      = cmd_len;
                    wdata_d    = cmd_wdata;
                    ss_d       = cmd_ss;
                    rdata_d    = 32'h0000_0000;
                    idx_d      = 2'd0;
                    err_d      = 1'b0;
                    poll_cnt_d = {PW{1'b0}};
                    ph_d       = 2'd0;
                    state_d    = S_WR_SS;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                if (ph_q != 2'd2) begin
                    ph_d = ph_q + 2'd1;
                end else if (poll_s) begin
                    ph_d = 2'd0;
                    if (poll_bit_s) begin
                        poll_cnt_d = {PW{1'b0}};
                        state_d    = poll_next_s;
                    end else if (poll_cnt_q == POLL_LAST) begin
                        poll_cnt_d = {PW{1'b0}};
                        err_d      = 1'b1;
                        state_d    = S_SSO_OFF;
                    end else begin
                        poll_cnt_d = poll_cnt_q + PW'(1);
                    end
                end else begin
                    ph_d = 2'd0;
                    case (state_q)
                        S_WR_SS:  state_d = S_SSO_ON;
                        S_SSO_ON: state_d = S_POLL_TRDY;
                        S_WR_TX:  state_d = S_POLL_RRDY;
                        S_RD_RX: begin
                            rdata_d = {rdata_q[23:0], data_to_cpu[7:0]};
                            idx_d   = idx_q + 2'd1;
                            if (idx_q == len_q) begin
                                state_d = S_POLL_TMT;
                            end else begin
                                state_d = S_POLL_TRDY;
                            end
                        end
                        S_SSO_OFF: begin
                            rsp_valid_d = 1'b1;
                            state_d     = S_DONE;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
        endcase
    end

    // Registered bus strobes, derived from the phase about to be entered.
    always_comb begin
        active_s     = bus_state_s && (ph_q != 2'd2);
        spi_select_d = active_s;
        read_n_d     = !(active_s && bus_rd_s);
        write_n_d    = !(active_s && !bus_rd_s);
        cmd_ready_d  = (state_d == S_IDLE);
        if (active_s) begin
            mem_addr_d = bus_addr_s;
            data_d     = bus_data_s;
        end else begin
            mem_addr_d = mem_addr_q;
            data_d     = data_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            ph_q         <= 2'd0;
            idx_q        <= 2'd0;
            len_q        <= 2'd0;
            wdata_q      <= 32'h0000_0000;
            ss_q         <= 16'h0000;
            rdata_q      <= 32'h0000_0000;
            err_q        <= 1'b0;
            poll_cnt_q   <= {PW{1'b0}};
            rsp_valid_q  <= 1'b0;
            cmd_ready_q  <= 1'b1;
            spi_select_q <= 1'b0;
            read_n_q     <= 1'b1;
            write_n_q    <= 1'b1;
            mem_addr_q   <= 3'd0;
            data_q       <= 16'h0000;
        end else begin
            state_q      <= state_d;
            ph_q         <= ph_d;
            idx_q        <= idx_d;
            len_q        <= len_d;
            wdata_q      <= wdata_d;
            ss_q         <= ss_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            poll_cnt_q   <= poll_cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            cmd_ready_q  <= cmd_ready_d;
            spi_select_q <= spi_select_d;
            read_n_q     <= read_n_d;
            write_n_q    <= write_n_d;
            mem_addr_q   <= mem_addr_d;
            data_q       <= data_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rdata_q;
    assign rsp_err       = err_q;
    assign mem_addr      = mem_addr_q;
    assign data_from_cpu = data_q;
    assign spi_select    = spi_select_q;
    assign read_n        = read_n_q;
    assign write_n       = write_n_q;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed bench: SPI master register model with loopback slave, bus protocol
// monitor, and hand-computed expectations for each command scenario.
module tb_spi_cmd_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_len;
    logic [31:0] cmd_wdata;
    logic [15:0] cmd_ss;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [2:0]  mem_addr;
    logic [15:0] data_from_cpu;
    logic [15:0] data_to_cpu;
    logic        spi_select;
    logic        read_n;
    logic        write_n;

    always #5 clk = ~clk;

    spi_cmd_sequencer #(.POLL_LIMIT(8)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_len(cmd_len), .cmd_wdata(cmd_wdata), .cmd_ss(cmd_ss),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu),
        .spi_select(spi_select), .read_n(read_n), .write_n(write_n)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // SPI master model state (written only by the monitor process)
    logic        pending = 1'b0;
    logic        rrdy    = 1'b0;
    logic        sso_on  = 1'b0;
    logic [7:0]  rx      = 8'h00;
    logic [15:0] ss_reg  = 16'h0000;
    int          pcnt    = 0;
    // Test controls (written only by the main process)
    logic        stuck   = 1'b0;
    int          delay   = 2;

    logic [19:0] bus_log[$];
    logic [7:0]  mosi[$];
    int ovl_cnt = 0, len_err = 0, strobe_err = 0, unstable_cnt = 0, ss_err = 0;

    always_comb begin
        data_to_cpu = 16'hDEAD;
        if (mem_addr == 3'd0) begin
            data_to_cpu = {8'h00, rx};
        end else if (mem_addr == 3'd2) begin
            data_to_cpu = stuck ? 16'h0000 : {8'h00, rrdy, !pending, !pending, 5'b00000};
        end
    end

    function automatic logic [19:0] acc(input logic rd, input logic [2:0] a, input logic [15:0] d);
        return {rd, a, d};
    endfunction

    // Bus monitor and register model
    initial begin
        int run;
        logic [19:0] cur;
        run = 0;
        cur = 20'h0;
        forever begin
            @(negedge clk);
            if (reset_n !== 1'b1) begin
                run = 0; pending = 1'b0; rrdy = 1'b0; sso_on = 1'b0; pcnt = 0;
            end else begin
                if (read_n === 1'b0 && write_n === 1'b0) ovl_cnt++;
                if (spi_select === 1'b1) begin
                    if (read_n === write_n) strobe_err++;
                    if (run == 0) begin
                        cur = {!read_n, mem_addr, data_from_cpu};
                    end else if (cur !== {!read_n, mem_addr, data_from_cpu}) begin
                        unstable_cnt++;
                    end
                    run++;
                end else begin
                    if (read_n !== 1'b1 || write_n !== 1'b1) strobe_err++;
                    if (run != 0) begin
                        if (run != 2) len_err++;
                        bus_log.push_back(cur);
                        if (cur[19]) begin
                            if (cur[18:16] == 3'd2 && pending) begin
                                pcnt++;
                                if (pcnt >= delay) begin
                                    rrdy = 1'b1;
                                    pending = 1'b0;
                                end
                            end else if (cur[18:16] == 3'd0) begin
                                rrdy = 1'b0;
                            end
                        end else begin
                            if (cur[18:16] == 3'd1) begin
                                if (!sso_on || ss_reg == 16'h0000) ss_err++;
                                rx = cur[7:0];
                                mosi.push_back(cur[7:0]);
                                pending = 1'b1;
                                pcnt = 0;
                            end else if (cur[18:16] == 3'd3) begin
                                sso_on = cur[10];
                            end else if (cur[18:16] == 3'd5) begin
                                ss_reg = cur[15:0];
                            end
                        end
                        run = 0;
                    end
                end
            end
        end
    end

    task automatic check_log(input string tag, input logic [19:0] exp[$]);
        int n;
        check_eq({tag, "_count"}, 32'(bus_log.size()), 32'(exp.size()));
        n = (bus_log.size() < exp.size()) ? bus_log.size() : exp.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s[%0d]", tag, i), 32'(bus_log[i]), 32'(exp[i]));
        end
    endtask

    task automatic run_cmd(input logic [1:0] len, input logic [31:0] wd, input logic [15:0] ss,
                           output logic [31:0] rd, output logic err);
        int k;
        bus_log.delete();
        mosi.delete();
        k = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_eq("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_len = len; cmd_wdata = wd; cmd_ss = ss;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        while (rsp_valid !== 1'b1 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check_eq("rsp_seen", 32'(rsp_valid), 32'd1);
        rd  = rsp_rdata;
        err = rsp_err;
        @(negedge clk);
        check_eq("rsp_pulse_end", 32'(rsp_valid), 32'd0);
        check_eq("rdata_hold", rsp_rdata, rd);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        logic [19:0] exp[$];
        logic [31:0] r[2];
        int acc_n, rsp_n, k;
        logic sw;

        reset_n = 1'b0; cmd_valid = 1'b0; cmd_len = 2'd0; cmd_wdata = 32'h0; cmd_ss = 16'h0;
        repeat (3) @(negedge clk);
        check_eq("rst_select", 32'(spi_select), 32'd0);
        check_eq("rst_read_n", 32'(read_n), 32'd1);
        check_eq("rst_write_n", 32'(write_n), 32'd1);
        check_eq("rst_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_wdata", 32'(data_from_cpu), 32'd0);
        check_eq("rst_rsp", 32'({rsp_valid, rsp_err}), 32'd0);
        check_eq("rst_rdata", rsp_rdata, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("rst_ready", 32'(cmd_ready), 32'd1);

        // Single byte loopback
        run_cmd(2'd0, 32'hA500_0000, 16'h0001, rd, err);
        exp = '{acc(0, 5, 16'h0001), acc(0, 3, 16'h0400), acc(1, 2, 0), acc(0, 1, 16'h00A5),
                acc(1, 2, 0), acc(1, 2, 0), acc(1, 2, 0), acc(1, 0, 0), acc(1, 2, 0),
                acc(0, 3, 16'h0000)};
        check_log("one_bus", exp);
        check_eq("one_rdata", rd, 32'h0000_00A5);
        check_eq("one_err", 32'(err), 32'd0);

        // Four bytes, MSB first
        run_cmd(2'd3, 32'h1234_5678, 16'h0004, rd, err);
        check_eq("four_mosi_n", 32'(mosi.size()), 32'd4);
        if (mosi.size() == 4) begin
            check_eq("four_mosi0", 32'(mosi[0]), 32'h12);
            check_eq("four_mosi1", 32'(mosi[1]), 32'h34);
            check_eq("four_mosi2", 32'(mosi[2]), 32'h56);
            check_eq("four_mosi3", 32'(mosi[3]), 32'h78);
        end
        check_eq("four_sso_on", 32'(bus_log[1]), 32'(acc(0, 3, 16'h0400)));
        check_eq("four_sso_off", 32'(bus_log[bus_log.size()-1]), 32'(acc(0, 3, 16'h0000)));
        check_eq("four_rdata", rd, 32'h1234_5678);
        check_eq("four_err", 32'(err), 32'd0);

        // Ready flag appears on the last permitted poll
        delay = 7;
        run_cmd(2'd1, 32'hC33C_0000, 16'h0002, rd, err);
        check_eq("edge_rdata", rd, 32'h0000_C33C);
        check_eq("edge_err", 32'(err), 32'd0);
        delay = 2;

        // Status stuck at zero: abort after exactly 8 polls
        stuck = 1'b1;
        run_cmd(2'd0, 32'hFF00_0000, 16'h0001, rd, err);
        exp = '{acc(0, 5, 16'h0001), acc(0, 3, 16'h0400), acc(1, 2, 0), acc(1, 2, 0),
                acc(1, 2, 0), acc(1, 2, 0), acc(1, 2, 0), acc(1, 2, 0), acc(1, 2, 0),
                acc(1, 2, 0), acc(0, 3, 16'h0000)};
        check_log("tmo_bus", exp);
        check_eq("tmo_err", 32'(err), 32'd1);
        check_eq("tmo_rdata", rd, 32'd0);
        stuck = 1'b0;

        // cmd_valid held through a command: second starts only after the response
        @(negedge clk);
        cmd_valid = 1'b1; cmd_len = 2'd0; cmd_wdata = 32'h3C00_0000; cmd_ss = 16'h0001;
        acc_n = 0; rsp_n = 0; sw = 1'b0; r[0] = 32'h0; r[1] = 32'h0;
        for (int c = 0; c < 4000 && rsp_n < 2; c++) begin
            if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
                check_eq("busy_accept_order", 32'(rsp_n), 32'(acc_n));
                acc_n++;
                sw = 1'b1;
            end
            @(negedge clk);
            if (sw) begin
                if (acc_n == 1) cmd_wdata = 32'h8100_0000;
                else cmd_valid = 1'b0;
                sw = 1'b0;
            end
            if (rsp_valid === 1'b1) begin
                r[rsp_n] = rsp_rdata;
                rsp_n++;
            end
        end
        cmd_valid = 1'b0;
        check_eq("busy_rsp_n", 32'(rsp_n), 32'd2);
        check_eq("busy_acc_n", 32'(acc_n), 32'd2);
        check_eq("busy_r0", r[0], 32'h0000_003C);
        check_eq("busy_r1", r[1], 32'h0000_0081);

        // Reset pulsed during the transmit write
        repeat (3) @(negedge clk);
        cmd_valid = 1'b1; cmd_len = 2'd1; cmd_wdata = 32'h7777_0000; cmd_ss = 16'h0001;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        while (!(write_n === 1'b0 && mem_addr === 3'd1) && k < 500) begin
            @(negedge clk);
            k++;
        end
        check_eq("rst_mid_reached", 32'(mem_addr), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("rst_mid_select", 32'(spi_select), 32'd0);
        check_eq("rst_mid_strobes", 32'({read_n, write_n}), 32'd3);
        check_eq("rst_mid_bus", 32'({mem_addr, data_from_cpu}), 32'd0);
        check_eq("rst_mid_rsp", 32'({rsp_valid, rsp_err}), 32'd0);
        check_eq("rst_mid_rdata", rsp_rdata, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_mid_idle", 32'({cmd_ready, spi_select}), 32'h2);
        run_cmd(2'd0, 32'h5A00_0000, 16'h0001, rd, err);
        check_eq("post_rst_rdata", rd, 32'h0000_005A);
        check_eq("post_rst_err", 32'(err), 32'd0);

        // Protocol invariants over the whole run
        check_eq("rw_overlap", 32'(ovl_cnt), 32'd0);
        check_eq("access_len", 32'(len_err), 32'd0);
        check_eq("strobe_select", 32'(strobe_err), 32'd0);
        check_eq("access_stable", 32'(unstable_cnt), 32'd0);
        check_eq("ss_held", 32'(ss_err), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
